// File: rtl/input_conditioner_pkg.sv
// Shared constants and the debounce-length helper for the input conditioner.
// Pure declarations: no latency, no flow control.
package input_conditioner_pkg;

`include "board_defs.vh"

    localparam int CLK_HZ_DEF      = `BOARD_CLK_HZ;
    localparam int DEBOUNCE_US_DEF = `BOARD_DEBOUNCE_US;
    localparam int N_SW            = `BOARD_N_SW;
    localparam int N_BTN           = `BOARD_N_BTN;

    // Cycles of disagreement needed before a level commits; never below one.
    function automatic int cnt_max_f(input int clk_hz, input int debounce_us);
        int c;
        c = (clk_hz / 1000000) * debounce_us;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/board_defs.vh
// Board-wide defaults shared by the conditioner and the board top.
`ifndef BOARD_DEFS_VH
`define BOARD_DEFS_VH
`define BOARD_CLK_HZ      100000000
`define BOARD_DEBOUNCE_US 10000
`define BOARD_N_SW        4
`define BOARD_N_BTN       4
`endif

// File: rtl/input_conditioner_debounce_ch.sv
// One channel: synchroniser, debounce counter, level, edge pulses and toggle latch.
// Latency SYNC_STAGES+CNT_MAX edges from a clean raw edge; free-running, no backpressure.
module input_conditioner_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_MAX     = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o,
    output logic evt_nxt_o
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle_q, toggle_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(CNT_MAX - 1)) begin
            // Full run of disagreement: commit and emit the matching pulse.
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
            if (s) begin
                toggle_d = ~toggle_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    assign level_o   = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign toggle_o  = toggle_q;
    assign evt_nxt_o = rise_d | fall_d;

endmodule

// File: rtl/input_conditioner.sv
// N-channel switch/button conditioner: debounced level, rise/fall pulses, toggle, any-event.
// Latency SYNC_STAGES+CNT_MAX edges per channel; free-running, no backpressure.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int CLK_HZ      = CLK_HZ_DEF,
    parameter int DEBOUNCE_US = DEBOUNCE_US_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] toggle_o,
    output logic            any_evt_o
);

    localparam int CNT_MAX = cnt_max_f(CLK_HZ, DEBOUNCE_US);

    logic [N_CH-1:0] evt_nxt;
    logic            any_evt_q, any_evt_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        input_conditioner_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_MAX     (CNT_MAX)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .raw_i     (raw_i[g]),
            .level_o   (level_o[g]),
            .rise_o    (rise_o[g]),
            .fall_o    (fall_o[g]),
            .toggle_o  (toggle_o[g]),
            .evt_nxt_o (evt_nxt[g])
        );
    end

    // Reduced from next-state pulses so the flop lands in the same cycle as RISE/FALL.
    assign any_evt_d = |evt_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            any_evt_q <= 1'b0;
        end else begin
            any_evt_q <= any_evt_d;
        end
    end

    assign any_evt_o = any_evt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner at N_CH=4, CNT_MAX=4, SYNC_STAGES=2.
module tb_input_conditioner;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int CMAX = 4;
    localparam int HL   = SYNC + CMAX;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw = '0;
    logic [N-1:0] level, rise, fall, toggle;
    logic         any_evt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: raw values seen at recent edges, newest first.
    logic [N-1:0] hist [HL];
    logic [N-1:0] m_level, m_rise, m_fall, m_tog;
    logic         m_any;

    typedef struct {
        logic [N-1:0] raw;
        int           hold;
        logic [N-1:0] exp_level;
        logic [N-1:0] exp_tog;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    input_conditioner #(
        .N_CH        (N),
        .CLK_HZ      (1000000),
        .DEBOUNCE_US (4),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .raw_i     (raw),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall),
        .toggle_o  (toggle),
        .any_evt_o (any_evt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist[k] = '0;
        m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_any = 1'b0;
    endtask

    // A channel commits when the synchronised value disagreed with the level on
    // each of the last CMAX edges; the synchronised value at an edge is the raw
    // value captured SYNC edges earlier.
    task automatic model_edge(input logic [N-1:0] r);
        for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = r;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N; c++) begin
            bit all_diff = 1'b1;
            for (int m = 0; m < CMAX; m++)
                if (hist[m + SYNC][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) begin
                    m_rise[c] = 1'b1;
                    m_tog[c]  = ~m_tog[c];
                end else begin
                    m_fall[c] = 1'b1;
                end
            end
        end
        m_any = |(m_rise | m_fall);
    endtask

    // Called at a falling edge: drive raw, take one rising edge, check at the next falling edge.
    task automatic tick(input logic [N-1:0] r);
        raw = r;
        @(posedge clk);
        if (rst_n) model_edge(r);
        else       model_reset();
        @(negedge clk);
        check("model", {15'd0, level, rise, fall, toggle, any_evt},
                       {15'd0, m_level, m_rise, m_fall, m_tog, m_any});
    endtask

    initial begin
        int lat;
        int cnt;
        logic [N-1:0] r;

        vecs[0] = '{4'b0000, 10, 4'b0000, 4'b1111};
        vecs[1] = '{4'b0101, 10, 4'b0101, 4'b1010};
        vecs[2] = '{4'b1111, 10, 4'b1111, 4'b0000};
        vecs[3] = '{4'b0110, 10, 4'b0110, 4'b0000};
        vecs[4] = '{4'b1001, 10, 4'b1001, 4'b1001};

        model_reset();
        @(negedge clk);

        // Reset held with inputs toggling.
        for (int k = 0; k < 6; k++) begin
            tick((k % 2 == 0) ? 4'b1111 : 4'b0000);
            check("rst_zero", {15'd0, level, rise, fall, toggle, any_evt}, 32'd0);
        end
        rst_n = 1'b1;
        tick(4'b0000);

        // Clean press on ch0.
        lat = -1; cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(4'b0001);
            if (rise[0]) begin
                cnt++;
                if (lat < 0) begin
                    lat = k;
                    check("press_any", {31'd0, any_evt}, 32'd1);
                    check("press_tog", {31'd0, toggle[0]}, 32'd1);
                end
            end
        end
        check("press_lat", lat, 6);
        check("press_once", cnt, 1);

        // Bounce on ch1: runs of 3 never reach 4.
        cnt = 0;
        for (int rep = 0; rep < 10; rep++) begin
            for (int k = 0; k < 4; k++) begin
                tick((k < 3) ? 4'b0011 : 4'b0001);
                if (rise[1] || fall[1]) cnt++;
            end
        end
        check("bounce_evt", cnt, 0);
        check("bounce_lvl", {31'd0, level[1]}, 32'd0);

        // Release ch0: FALL with toggle still set.
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(4'b0000);
            if (fall[0] && lat < 0) begin
                lat = k;
                check("rel_tog", {31'd0, toggle[0]}, 32'd1);
                check("rel_norise", {28'd0, rise}, 32'd0);
            end
        end
        check("rel_lat", lat, 6);

        // Repress ch0: toggle clears on RISE.
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(4'b0001);
            if (rise[0] && lat < 0) lat = k;
        end
        check("repress_lat", lat, 6);
        check("repress_tog", {31'd0, toggle[0]}, 32'd0);
        for (int k = 0; k < 10; k++) tick(4'b0000);

        // Simultaneous press on all channels.
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(4'b1111);
            if (rise == 4'b1111 && lat < 0) begin
                lat = k;
                check("simul_any", {31'd0, any_evt}, 32'd1);
                tick(4'b1111);
                check("simul_any_off", {31'd0, any_evt}, 32'd0);
                k++;
            end
        end
        check("simul_lat", lat, 6);

        // Table of held patterns.
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].hold; k++) tick(vecs[i].raw);
            check($sformatf("vec%0d_lvl", i), {28'd0, level}, {28'd0, vecs[i].exp_level});
            check($sformatf("vec%0d_tog", i), {28'd0, toggle}, {28'd0, vecs[i].exp_tog});
        end
        for (int k = 0; k < 10; k++) tick(4'b0000);

        // Reset mid-count on ch2.
        for (int k = 0; k < 4; k++) tick(4'b0100);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_zero", {15'd0, level, rise, fall, toggle, any_evt}, 32'd0);
        tick(4'b0100);
        tick(4'b0100);
        rst_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(4'b0100);
            if (level[2] && lat < 0) lat = k;
        end
        check("midrst_lat", lat, 6);

        // Random sticky inputs against the reference.
        r = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
            tick(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
